// File: rtl/aes_dec_ctrl.sv
// aes_dec_ctrl: control wrapper around an iterative AES decryption core.
//   - Holds the round-key table (NUM_ROUNDS+1 x 128b). The table is written in IDLE only.
//     The core reads it combinationally by round index.
//   - Accepts one ciphertext block over a valid/ready handshake.
//   - Launches the core with a one-cycle start pulse and waits for done, bounded by TIMEOUT.
//   - Presents the plaintext on a valid/ready output. A new block is not taken while a
//     result is still pending.
// Ports:
//   clk, reset (sync, active high)
//   key_wr_en/key_wr_addr/key_wr_data, key_load_done : key table load
//   s_valid/s_data/s_ready                            : ciphertext in
//   m_valid/m_data/m_ready                            : plaintext out
//   core_start, core_data_in, core_key_in,
//   core_key_expansion_done, core_desired_round,
//   core_data_out, core_done                          : decryption core link
//   key_valid, busy, timeout_err, blk_count           : status

// One round-key entry. Cleared on reset; loaded when its write strobe fires.
module aes_dec_key_slot (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [127:0] wdata,
  output logic [127:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (we) q <= wdata;
  end
endmodule

module aes_dec_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_wr_en,
  input  logic [3:0]   key_wr_addr,
  input  logic [127:0] key_wr_data,
  input  logic         key_load_done,
  input  logic         s_valid,
  input  logic [127:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [127:0] m_data,
  input  logic         m_ready,
  output logic         core_start,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key_in,
  output logic         core_key_expansion_done,
  input  logic [3:0]   core_desired_round,
  input  logic [127:0] core_data_out,
  input  logic         core_done,
  output logic         key_valid,
  output logic         busy,
  output logic         timeout_err,
  output logic [15:0]  blk_count
);
  localparam int NK = NUM_ROUNDS + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t                    state, state_n;
  logic [CW-1:0]             run_cnt;
  logic [NUM_ROUNDS:0][127:0] key_q;
  logic                      key_we, accept, fin, tmo;

  // Writes outside IDLE or beyond the last round are dropped silently.
  assign key_we = key_wr_en && (state == IDLE) && (key_wr_addr <= 4'(NUM_ROUNDS));

  for (genvar g = 0; g < NK; g++) begin : g_slot
    aes_dec_key_slot u_slot (
      .clk   (clk),
      .reset (reset),
      .we    (key_we && (key_wr_addr == 4'(g))),
      .wdata (key_wr_data),
      .q     (key_q[g])
    );
  end

  // Zero-latency key lookup; out-of-range rounds read as zero.
  always_comb begin
    core_key_in = '0;
    if (core_desired_round <= 4'(NUM_ROUNDS)) core_key_in = key_q[core_desired_round];
  end

  assign s_ready                 = (state == IDLE) && key_valid && !m_valid;
  assign core_start              = (state == START);
  assign busy                    = (state != IDLE);
  assign core_key_expansion_done = key_valid;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    fin     = 1'b0;
    tmo     = 1'b0;
    case (state)
      IDLE:  if (s_valid && s_ready) begin
               accept  = 1'b1;
               state_n = START;
             end
      START: state_n = RUN;
      RUN:   if (core_done) begin
               // done beats a timeout landing on the same cycle
               fin     = 1'b1;
               state_n = IDLE;
             end else if (run_cnt == CW'(TIMEOUT - 1)) begin
               tmo     = 1'b1;
               state_n = IDLE;
             end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      run_cnt      <= '0;
      core_data_in <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      blk_count    <= '0;
      timeout_err  <= 1'b0;
      key_valid    <= 1'b0;
    end else begin
      state   <= state_n;
      run_cnt <= (state == RUN) ? run_cnt + CW'(1) : '0;
      if (accept) core_data_in <= s_data;
      if (fin) begin
        m_data    <= core_data_out;
        blk_count <= blk_count + 16'd1;
      end
      if (fin)                     m_valid <= 1'b1;
      else if (m_valid && m_ready) m_valid <= 1'b0;
      if (tmo) timeout_err <= 1'b1;
      // load_done wins over a same-cycle write so the table ends up valid
      if ((state == IDLE) && key_load_done) key_valid <= 1'b1;
      else if (key_we)                      key_valid <= 1'b0;
    end
  end
endmodule

// File: doc/aes_dec_ctrl.md
AES_DEC_CTRL -- requirements
Module: aes_dec_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, number of AES rounds; the key table holds NUM_ROUNDS+1 entries, indexed 0..NUM_ROUNDS.
REQ-002 Parameter TIMEOUT, default 64, maximum number of cycles in RUN before the block aborts.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_wr_en / key_wr_addr / key_wr_data  input  1/4/128  round-key table write port.
REQ-006 key_load_done  input  1  one-cycle pulse marking the key table complete.
REQ-007 s_valid / s_data  input  1/128  ciphertext request; s_ready  output  1  accept.
REQ-008 m_valid / m_data  output  1/128  plaintext result; m_ready  input  1  consume.
REQ-009 core_start  output  1  start pulse to the decryption core.
REQ-010 core_data_in / core_key_in  output  128/128  data and round key driven to the core.
REQ-011 core_key_expansion_done  output  1  equal to key_valid.
REQ-012 core_desired_round  input  4; core_data_out  input  128; core_done  input  1.
REQ-013 key_valid / busy / timeout_err  output  1 each; blk_count  output  16  count of completed blocks.

Function
REQ-014 Key table writes SHALL be accepted only in IDLE, with key_wr_addr <= NUM_ROUNDS; all other writes SHALL be ignored.
REQ-015 An accepted write SHALL clear key_valid on the next cycle; key_load_done in IDLE SHALL set key_valid; if both occur in the same cycle, the write SHALL take effect and key_valid SHALL end at 1.
REQ-016 core_key_in SHALL be a combinational read of key_table[core_desired_round] (zero latency); an index > NUM_ROUNDS SHALL yield 0.
REQ-017 The FSM SHALL have exactly three states: IDLE, START and RUN.
REQ-018 s_ready SHALL equal (state==IDLE && key_valid && !m_valid).
REQ-019 IDLE->START on s_valid&&s_ready; in that cycle s_data SHALL be latched into core_data_in.
REQ-020 In START, core_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to RUN.
REQ-021 core_data_in SHALL hold stable from START until the FSM returns to IDLE.
REQ-022 In RUN, a cycle counter SHALL count from 0; on core_done the FSM SHALL capture core_data_out into m_data, set m_valid, increment blk_count (wrapping 0xFFFF->0) and return to IDLE.
REQ-023 If core_done has not been seen when the RUN counter reaches TIMEOUT-1, the FSM SHALL set timeout_err (sticky until reset), leave m_valid unchanged and return to IDLE.
REQ-024 If core_done arrives in the same cycle as the timeout, core_done SHALL win and timeout_err SHALL stay unchanged.
REQ-025 core_done outside RUN SHALL be ignored.
REQ-026 m_valid SHALL clear on m_valid&&m_ready; m_data SHALL hold its value while m_valid=1.
REQ-027 The next request SHALL be accepted no earlier than the cycle after m_valid clears; there is no bypass path.
REQ-028 busy SHALL be 1 in START and RUN.
REQ-029 End-to-end latency SHALL be the core latency plus 2 cycles, measured from s_valid&&s_ready to m_valid.

Reset
REQ-030 On reset the block SHALL return to IDLE, discard any in-flight block, and clear every output and register to 0 (including m_valid, m_data, key_valid, timeout_err, blk_count, core_start and core_data_in).
REQ-031 On reset the key table SHALL be cleared to 0.
REQ-032 A reset asserted during RUN SHALL produce no m_valid for the aborted block.

Verification
REQ-033 Load: keys written to addresses 0..10 (addr 0 = 615a997f702144e73d121dca98b80f54, addr 10 = 12345678998765432112345678998765), then key_load_done -> key_valid=1 next cycle; core_desired_round=10 -> core_key_in = 1234...8765 in the same cycle.
REQ-034 Decrypt: s_data=12ad1fabae6a5dbdcbddb54e670161e9 with a core model -> exactly one core_start pulse, then m_valid=1 with m_data = core_data_out, and blk_count=1.
REQ-035 Backpressure: hold m_ready=0 and present a second s_valid -> s_ready stays 0 and m_data is stable; m_ready=1 -> next cycle the second block is accepted.
REQ-036 Timeout: core never asserts done -> timeout_err=1 after TIMEOUT cycles in RUN, FSM back in IDLE, m_valid=0; core_done on the exact timeout cycle -> m_valid=1 and timeout_err=0.
REQ-037 Key write during RUN to addr 3 -> table unchanged and key_valid stays 1; write to addr 11 in IDLE -> ignored.
REQ-038 Reset in RUN -> next cycle all outputs are 0, no m_valid for the aborted block, key_valid=0, and s_ready=0 until keys are reloaded.
